// File: rtl/prog_freq_div_pkg.sv
// Shared constants, divisor-slot state and the half-period helper for prog_freq_divider.
package prog_freq_div_pkg;

  localparam int MIN_DIV = 2;
  // Widest divisor the helper supports; WIDTH must not exceed it.
  localparam int MAX_W   = 32;

  typedef enum logic {
    PEND_EMPTY,
    PEND_FULL
  } pend_state_e;

  // ceil(n/2) computed one bit wider so n = 2^MAX_W-1 cannot overflow.
  function automatic logic [MAX_W-1:0] half_ceil(input logic [MAX_W-1:0] n);
    logic [MAX_W:0] sum;
    sum = {1'b0, n} + {{MAX_W{1'b0}}, 1'b1};
    return sum[MAX_W:1];
  endfunction

endpackage

// File: rtl/prog_freq_divider_sync.sv
// sync_rise_detect: two-flop synchroniser followed by a one-cycle rising-edge pulse.
module sync_rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  // [0],[1] synchronise; [2] holds the previous synchronised value.
  logic [2:0] sync_q;
  logic [2:0] sync_d;

  assign sync_d = {sync_q[1:0], async_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/prog_freq_divider.sv
// Programmable clock divider: square wave d plus one-cycle tick per period, divisor loaded by
// valid/ready and applied at a period boundary. Define PROG_FREQ_DIV_SYNC_IN_EN to add sync_in.
module prog_freq_divider
  import prog_freq_div_pkg::*;
#(
  parameter int WIDTH       = 21,
  parameter int DEFAULT_DIV = 1048576
) (
  input  logic             clk,
  input  logic             rst,
`ifdef PROG_FREQ_DIV_SYNC_IN_EN
  input  logic             sync_in,
`endif
  input  logic             en,
  input  logic             sclr,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_valid,
  output logic             div_ready,
  output logic             div_err,
  output logic             d,
  output logic             tick,
  output logic [WIDTH-1:0] cur_div
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] cur_div_q, cur_div_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  pend_state_e      pend_state_q, pend_state_d;
  logic             d_q, d_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;

  logic             restart;
  logic             accept;
  logic             last;
  logic             apply;
  logic [MAX_W-1:0] h_next;

`ifdef PROG_FREQ_DIV_SYNC_IN_EN
  logic sync_pulse;

  sync_rise_detect u_sync (
    .clk      (clk),
    .rst_n    (rst),
    .async_in (sync_in),
    .rise     (sync_pulse)
  );

  assign restart = sclr | sync_pulse;
`else
  assign restart = sclr;
`endif

  assign div_ready = (pend_state_q == PEND_EMPTY);
  assign accept    = div_valid & div_ready;
  assign last      = (cnt_q == (cur_div_q - WIDTH'(1)));

  always_comb begin
    cnt_d        = cnt_q;
    cur_div_d    = cur_div_q;
    pend_d       = pend_q;
    pend_state_d = pend_state_q;
    tick_d       = 1'b0;
    err_d        = 1'b0;
    apply        = 1'b0;

    if (restart) begin
      cnt_d = '0;
      apply = (pend_state_q == PEND_FULL);
    end else if (en) begin
      if (last) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        apply  = (pend_state_q == PEND_FULL);
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end

    if (apply) begin
      cur_div_d    = pend_q;
      pend_state_d = PEND_EMPTY;
    end

    // Acceptance needs an empty slot, so it never coincides with an apply.
    if (accept) begin
      if (div_in < WIDTH'(MIN_DIV)) begin
        err_d = 1'b1;
      end else begin
        pend_d       = div_in;
        pend_state_d = PEND_FULL;
      end
    end

    // d is registered alongside cnt so d == (cnt < H) holds in every cycle.
    h_next = half_ceil(MAX_W'(cur_div_d));
    d_d    = (MAX_W'(cnt_d) < h_next);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= '0;
      cur_div_q    <= WIDTH'(DEFAULT_DIV);
      pend_q       <= '0;
      pend_state_q <= PEND_EMPTY;
      d_q          <= 1'b1;
      tick_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      cur_div_q    <= cur_div_d;
      pend_q       <= pend_d;
      pend_state_q <= pend_state_d;
      d_q          <= d_d;
      tick_q       <= tick_d;
      err_q        <= err_d;
    end
  end

  assign d       = d_q;
  assign tick    = tick_q;
  assign div_err = err_q;
  assign cur_div = cur_div_q;

endmodule

// File: tb/tb_prog_freq_divider.sv
// Scoreboard bench for prog_freq_divider (WIDTH=4, DEFAULT_DIV=6): stimulus queues per-cycle
// expectations, a negedge monitor pops and compares them and flags stray tick/div_err pulses.
module tb_prog_freq_divider;

  logic       clk;
  logic       rst;
  logic       en;
  logic       sclr;
  logic [3:0] div_in;
  logic       div_valid;
  logic       div_ready;
  logic       div_err;
  logic       d;
  logic       tick;
  logic [3:0] cur_div;

  typedef struct {
    int         cyc;
    logic       d;
    logic       t;
    logic       e;
    logic       r;
    logic [3:0] cur;
  } exp_t;

  exp_t  sb[$];
  string tq[$];
  int    cyc;
  int    errors;
  int    checks;
  logic  mon_on;
  logic  done;

  prog_freq_divider #(
    .WIDTH       (4),
    .DEFAULT_DIV (6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sclr      (sclr),
    .div_in    (div_in),
    .div_valid (div_valid),
    .div_ready (div_ready),
    .div_err   (div_err),
    .d         (d),
    .tick      (tick),
    .cur_div   (cur_div)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic push(input int c, input logic xd, input logic xt, input logic xe,
                      input logic xr, input logic [3:0] xc, input string tag);
    exp_t e;
    e.cyc = c;
    e.d   = xd;
    e.t   = xt;
    e.e   = xe;
    e.r   = xr;
    e.cur = xc;
    sb.push_back(e);
    tq.push_back(tag);
  endtask

  // Drive inputs for the next edge and queue the state expected after it.
  task automatic cyc1(input logic e_v, input logic s_v, input logic v_v, input logic [3:0] din,
                      input logic xd, input logic xt, input logic xe, input logic xr,
                      input logic [3:0] xc, input string tag);
    en        = e_v;
    sclr      = s_v;
    div_valid = v_v;
    div_in    = din;
    push(cyc + 1, xd, xt, xe, xr, xc, tag);
    @(posedge clk);
    #1;
  endtask

  task automatic seg(input string dp, input string tp, input logic [3:0] xc, input logic xr,
                     input string tag);
    for (int i = 0; i < dp.len(); i++)
      cyc1(1'b1, 1'b0, 1'b0, 4'd0, dp[i] == "1", tp[i] == "1", 1'b0, xr, xc, tag);
  endtask

  initial begin
    string held;
    rst = 1'b0; en = 1'b1; sclr = 1'b0; div_valid = 1'b0; div_in = 4'd0;
    mon_on = 1'b0; done = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    push(0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd6, "reset");
    mon_on = 1'b1;

    // Default divisor 6: 3 high / 3 low, tick every 6.
    seg("110001110001", "000001000001", 4'd6, 1'b1, "default6");
    // Load 5 mid-period; it waits for the wrap.
    seg("11", "00", 4'd6, 1'b1, "pre_load");
    cyc1(1'b1, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6, "load5");
    seg("00", "00", 4'd6, 1'b0, "pend5");
    seg("1", "1", 4'd5, 1'b1, "apply5");
    seg("1100111001", "0000100001", 4'd5, 1'b1, "odd5");
    // Rejected divisors 1 and 0.
    cyc1(1'b1, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd5, "rej1");
    seg("1", "0", 4'd5, 1'b1, "rej_gap");
    cyc1(1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd5, "rej0");
    seg("01", "01", 4'd5, 1'b1, "rej_after");
    // en low for 4 cycles in the high phase, then once on the wrap cycle.
    seg("1", "0", 4'd5, 1'b1, "pre_hold");
    repeat (4) cyc1(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd5, "hold");
    seg("100", "000", 4'd5, 1'b1, "resume");
    cyc1(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5, "hold_wrap");
    seg("1", "1", 4'd5, 1'b1, "wrap_after_hold");
    // sclr applies pending 7 immediately.
    cyc1(1'b1, 1'b0, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5, "load7");
    seg("1", "0", 4'd5, 1'b0, "pend7");
    cyc1(1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd7, "sclr_apply");
    seg("1110001", "0000001", 4'd7, 1'b1, "div7");
    seg("111000", "000000", 4'd7, 1'b1, "pre_wrap7");
    // sclr on a wrap cycle: no tick; a load of 15 in the same cycle is still accepted.
    cyc1(1'b1, 1'b1, 1'b1, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0, 4'd7, "sclr_wrap");
    // Second load (3) held off until 15 applies.
    held = "111000";
    for (int i = 0; i < 6; i++)
      cyc1(1'b1, 1'b0, 1'b1, 4'd3, held[i] == "1", 1'b0, 1'b0, 1'b0, 4'd7, "held_off");
    cyc1(1'b1, 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1, 4'd15, "apply15");
    cyc1(1'b1, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 4'd15, "load3");
    seg("1111110000000", "0000000000000", 4'd15, 1'b0, "div15");
    seg("1", "1", 4'd3, 1'b1, "apply3");
    seg("101101", "001001", 4'd3, 1'b1, "div3");
    done = 1'b1;
  end

  always @(negedge clk) begin
    if (mon_on) begin
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        exp_t  e;
        string tg;
        e  = sb.pop_front();
        tg = tq.pop_front();
        checks++;
        if ({d, tick, div_err, div_ready, cur_div} !== {e.d, e.t, e.e, e.r, e.cur}) begin
          errors++;
          $display("FAIL %s cyc=%0d got d=%b tick=%b err=%b rdy=%b cur=%0d want d=%b tick=%b err=%b rdy=%b cur=%0d",
                   tg, cyc, d, tick, div_err, div_ready, cur_div, e.d, e.t, e.e, e.r, e.cur);
        end
      end else if (tick || div_err) begin
        checks++;
        errors++;
        $display("FAIL stray_pulse cyc=%0d got tick=%b err=%b want tick=0 err=0", cyc, tick, div_err);
      end
      if (done || cyc > 300) begin
        checks++;
        if (!done || sb.size() != 0) begin
          errors++;
          $display("FAIL drain cyc=%0d got pending=%0d done=%b want pending=0 done=1",
                   cyc, sb.size(), done);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
  end

endmodule
